// File: rtl/mips_mem_pkg.sv
// Shared data-memory definitions: access size encodings, controller states and lane helpers.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Store byte-lane enables; reserved size 3 behaves as a word.
    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            SIZE_B:  be = 4'b0001 << off;
            SIZE_H:  be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        lanes = wdata;
        case (size)
            SIZE_B:  lanes = {4{wdata[7:0]}};
            SIZE_H:  lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Data-memory req/ack bus between the MEM-stage controller (master) and memory (slave).
interface dmem_stall_ctrl_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output ack,
        output rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the addressed byte/half and zero/sign extends it.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (size)
            SIZE_B:  result = {{24{sext & byte_sel[7]}}, byte_sel};
            SIZE_H:  result = {{16{sext & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory access controller: issues bus requests, stalls the pipeline until
// completion or timeout, and aligns load data / steers store lanes.
module dmem_stall_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_MEM,
    input  logic              mem_write_MEM,
    input  logic [1:0]        size_MEM,
    input  logic              sext_MEM,
    input  logic [31:0]       addr_MEM,
    input  logic [31:0]       wdata_MEM,
    dmem_stall_ctrl_if.master bus,
    output logic [31:0]       rdata_MEM,
    output logic              mem_stall_MEM,
    output logic              misalign_MEM,
    output logic              bus_err_MEM
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [1:0]       ld_off_q, ld_off_d;
    logic [1:0]       ld_size_q, ld_size_d;
    logic             ld_sext_q, ld_sext_d;

    logic [1:0]  off;
    logic        access;
    logic [31:0] aligned;

    assign off          = addr_MEM[1:0];
    assign misalign_MEM = misaligned(size_MEM, off);
    assign access       = (mem_read_MEM | mem_write_MEM) & ~misalign_MEM;

    // Alignment uses the attributes latched at issue, independent of the MEM-stage inputs.
    mem_load_align u_load_align (
        .rdata  (bus.rdata),
        .off    (ld_off_q),
        .size   (ld_size_q),
        .sext   (ld_sext_q),
        .result (aligned)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ld_off_d  = ld_off_q;
        ld_size_d = ld_size_q;
        ld_sext_d = ld_sext_q;

        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = mem_write_MEM;
                    addr_d    = {addr_MEM[31:2], 2'b00};
                    be_d      = mem_write_MEM ? be_of(size_MEM, off) : 4'b1111;
                    wdata_d   = store_lanes(size_MEM, wdata_MEM);
                    ld_off_d  = off;
                    ld_size_d = size_MEM;
                    ld_sext_d = sext_MEM;
                end
            end
            ST_WAIT: begin
                // An ack coinciding with the last allowed cycle wins over the timeout.
                if (bus.ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = aligned;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ld_off_q  <= '0;
            ld_size_q <= '0;
            ld_sext_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            ld_off_q  <= ld_off_d;
            ld_size_q <= ld_size_d;
            ld_sext_q <= ld_sext_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;

    assign rdata_MEM     = rdata_q;
    assign bus_err_MEM   = err_q;
    assign mem_stall_MEM = ((state_q == ST_IDLE) & access) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl: transaction-level expectation model plus a per-cycle compare.
module tb_dmem_stall_ctrl;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_MEM, mem_write_MEM, sext_MEM;
    logic [1:0]  size_MEM;
    logic [31:0] addr_MEM, wdata_MEM;
    logic [31:0] rdata_MEM;
    logic        mem_stall_MEM, misalign_MEM, bus_err_MEM;

    dmem_stall_ctrl_if bus ();

    dmem_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_MEM  (mem_read_MEM),
        .mem_write_MEM (mem_write_MEM),
        .size_MEM      (size_MEM),
        .sext_MEM      (sext_MEM),
        .addr_MEM      (addr_MEM),
        .wdata_MEM     (wdata_MEM),
        .bus           (bus),
        .rdata_MEM     (rdata_MEM),
        .mem_stall_MEM (mem_stall_MEM),
        .misalign_MEM  (misalign_MEM),
        .bus_err_MEM   (bus_err_MEM)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Expected outputs for the current cycle, set by the stimulus tasks.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_mis, exp_req, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    // Observations used by the literal checks.
    int          stall_cnt = 0;
    int          err_cnt   = 0;
    logic        req_seen  = 1'b0;
    logic [3:0]  seen_be   = '0;
    logic [31:0] seen_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_stall_MEM", {31'd0, mem_stall_MEM}, {31'd0, exp_stall});
            check("misalign_MEM", {31'd0, misalign_MEM}, {31'd0, exp_mis});
            check("bus_req", {31'd0, bus.req}, {31'd0, exp_req});
            check("bus_err_MEM", {31'd0, bus_err_MEM}, {31'd0, exp_err});
            check("rdata_MEM", rdata_MEM, exp_rdata);
            if (exp_req) begin
                check("bus_we", {31'd0, bus.we}, {31'd0, exp_we});
                check("bus_addr", bus.addr, exp_addr);
                check("bus_be", {28'd0, bus.be}, {28'd0, exp_be});
                check("bus_wdata", bus.wdata, exp_wdata);
            end
            if (mem_stall_MEM) stall_cnt++;
            if (bus_err_MEM) err_cnt++;
            if (bus.req) begin
                req_seen   = 1'b1;
                seen_be    = bus.be;
                seen_wdata = bus.wdata;
            end
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic tb_mis(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] tb_be(input logic rd, input logic [1:0] sz,
                                         input logic [31:0] a);
        logic [3:0] be;
        int         o;
        be = '0;
        o  = int'(a[1:0]);
        if (rd) return 4'hF;
        for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + nbytes(sz));
        return be;
    endfunction

    function automatic logic [31:0] tb_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        int          n;
        w = wd;
        n = nbytes(sz);
        if (n < 4) begin
            for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] tb_load(input logic [1:0] sz, input logic sx,
                                            input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v, mask;
        int          n;
        n = nbytes(sz);
        v = word >> (8 * int'(a[1:0]));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (sx && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_stall = 1'b0;
        exp_mis   = 1'b0;
        exp_req   = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_read_MEM  = 1'b0;
        mem_write_MEM = 1'b0;
        size_MEM      = 2'd0;
        addr_MEM      = '0;
        set_idle_exp();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // ack_cyc: WAIT cycle index (0 = first req cycle) carrying ack; negative = never.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sx, input logic [31:0] a, input logic [31:0] wd,
                              input int ack_cyc, input logic [31:0] rword);
        int n_wait;
        mem_read_MEM  = rd;
        mem_write_MEM = wr;
        size_MEM      = sz;
        sext_MEM      = sx;
        addr_MEM      = a;
        wdata_MEM     = wd;
        bus.rdata     = rword;
        exp_mis       = tb_mis(sz, a);
        exp_err       = 1'b0;
        exp_req       = 1'b0;
        if (exp_mis) begin
            exp_stall = 1'b0;
            @(posedge clk); #1;
            return;
        end
        n_wait    = (ack_cyc < 0) ? int'(TIMEOUT) : ack_cyc + 1;
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req   = 1'b1;
        exp_we    = wr;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = tb_be(rd, sz, a);
        exp_wdata = tb_wdata(sz, wd);
        for (int w = 0; w < n_wait; w++) begin
            bus.ack = (w == ack_cyc);
            @(posedge clk); #1;
        end
        bus.ack   = 1'b0;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        exp_err   = (ack_cyc < 0);
        if (rd && ack_cyc >= 0) exp_rdata = tb_load(sz, sx, a, rword);
        @(posedge clk); #1;
        exp_err = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_read_MEM  = 1'b0;
        mem_write_MEM = 1'b0;
        size_MEM      = 2'd0;
        sext_MEM      = 1'b0;
        addr_MEM      = '0;
        wdata_MEM     = '0;
        bus.ack       = 1'b0;
        bus.rdata     = '0;
        exp_rdata     = '0;
        exp_we        = 1'b0;
        exp_addr      = '0;
        exp_be        = '0;
        exp_wdata     = '0;
        set_idle_exp();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // lw, ack on the first req cycle
        stall_cnt = 0;
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("lw_rdata_literal", rdata_MEM, 32'hDEADBEEF);
        check("lw_stall_cycles", stall_cnt, 2);
        check("lw_be_literal", {28'd0, seen_be}, 32'hF);

        // lb / lbu at byte 3, lh at upper half
        run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80112233);
        check("lb_literal", rdata_MEM, 32'hFFFFFF80);
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80112233);
        check("lbu_literal", rdata_MEM, 32'h00000080);
        run_access(1'b1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1, 32'hF00D1234);
        run_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 0, 32'hF00D8234);

        // sh with three extra wait cycles, sb, sw
        stall_cnt = 0;
        run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 3, 32'h0);
        check("sh_stall_cycles", stall_cnt, 5);
        check("sh_be_literal", {28'd0, seen_be}, 32'hC);
        check("sh_wdata_literal", seen_wdata, 32'hABCDABCD);
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000005A, 0, 32'h0);
        check("sb_be_literal", {28'd0, seen_be}, 32'h2);
        run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h104, 32'h12345678, 1, 32'h0);
        idle(1);

        // misaligned accesses never reach the bus
        req_seen  = 1'b0;
        stall_cnt = 0;
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 32'h0);
        run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h201, 32'h1111, 0, 32'h0);
        idle(2);
        check("misalign_no_req", {31'd0, req_seen}, 32'd0);
        check("misalign_no_stall", stall_cnt, 0);

        // timeout, then ack on the last permitted cycle
        stall_cnt = 0;
        err_cnt   = 0;
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, -1, 32'h55555555);
        check("timeout_stall_cycles", stall_cnt, 17);
        check("timeout_err_cycles", err_cnt, 1);
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h304, 32'h0, int'(TIMEOUT) - 1, 32'hCAFEF00D);
        check("late_ack_no_err", err_cnt, 1);
        run_access(1'b1, 1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 0, 32'h01234567);

        // reset in the middle of WAIT, then a spurious ack
        chk_en        = 1'b0;
        mem_read_MEM  = 1'b1;
        size_MEM      = 2'd2;
        addr_MEM      = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("req_before_reset", {31'd0, bus.req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("req_async_reset", {31'd0, bus.req}, 32'd0);
        check("rdata_async_reset", rdata_MEM, 32'd0);
        mem_read_MEM = 1'b0;
        addr_MEM     = '0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        exp_rdata = '0;
        set_idle_exp();
        chk_en    = 1'b1;
        bus.ack   = 1'b1;
        bus.rdata = 32'hBADBADBA;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        idle(2);

        // back-to-back load then store
        run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 0, 32'h87654321);
        run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h504, 32'hA5A5A5A5, 0, 32'h0);
        idle(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
